// File: rtl/hdmi_sync_lock_ctrl.sv
// Sync-lock sequencer between CGA timing and the HDMI port: measures line and frame
// geometry, declares lock after a run of consistent frames, and gates/delays DE.
module hdmi_sync_lock_ctrl #(
    parameter int HCNT_W      = 12,
    parameter int VCNT_W      = 10,
    parameter int HTOL        = 2,
    parameter int LOCK_FRAMES = 4,
    parameter int LOSS_FRAMES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              display_enable,
    input  logic [1:0]        de_delay,
    output logic              de_out,
    output logic              locked,
    output logic              frame_strobe,
    output logic [HCNT_W-1:0] h_total,
    output logic [VCNT_W-1:0] v_total
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam int                FCNT_W   = 4;
    localparam logic [HCNT_W-1:0] H_MAX    = '1;
    localparam logic [VCNT_W-1:0] V_MAX    = '1;
    localparam logic [HCNT_W-1:0] H_TOL    = HCNT_W'(HTOL);
    localparam logic [FCNT_W-1:0] LOCK_TGT = FCNT_W'(LOCK_FRAMES);
    localparam logic [FCNT_W-1:0] LOSS_TGT = FCNT_W'(LOSS_FRAMES);

    // Edge detection
    logic hs_dly_q;
    logic vs_dly_q;
    logic hs_rise;
    logic vs_rise;

    // Line / frame measurement
    logic [HCNT_W-1:0] h_cnt_q,  h_cnt_d;
    logic [HCNT_W-1:0] h_last_q, h_last_d;
    logic [VCNT_W-1:0] v_cnt_q,  v_cnt_d;
    logic              bad_line_q, bad_line_d;
    logic [HCNT_W-1:0] h_len;
    logic [HCNT_W-1:0] h_dev;
    logic              line_bad;
    logic              frame_bad_line;
    logic [VCNT_W-1:0] v_len;
    logic              frame_good;
    logic              watchdog;

    // Lock sequencing
    state_e            state_q, state_d;
    logic [HCNT_W-1:0] h_ref_q, h_ref_d;
    logic [VCNT_W-1:0] v_ref_q, v_ref_d;
    logic [FCNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [FCNT_W-1:0] bad_cnt_q,  bad_cnt_d;

    // Output stage
    logic [2:0]        de_hist_q, de_hist_d;
    logic [3:0]        de_taps;
    logic              de_out_q, de_out_d;
    logic              locked_q, locked_d;
    logic              frame_strobe_q;
    logic [HCNT_W-1:0] h_total_q, h_total_d;
    logic [VCNT_W-1:0] v_total_q, v_total_d;

    assign hs_rise = hsync & ~hs_dly_q;
    assign vs_rise = vsync & ~vs_dly_q;

    // A line closing on the same clock as vs_rise belongs to the frame that is ending,
    // so its length and its count are folded in combinationally before the frame is judged.
    always_comb begin
        h_len          = (h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 1'b1;
        h_dev          = (h_len >= h_ref_q) ? (h_len - h_ref_q) : (h_ref_q - h_len);
        line_bad       = hs_rise && (h_dev > H_TOL);
        frame_bad_line = bad_line_q | line_bad;
        v_len          = (hs_rise && (v_cnt_q != V_MAX)) ? v_cnt_q + 1'b1 : v_cnt_q;
        frame_good     = !frame_bad_line && (v_len == v_ref_q);
        watchdog       = (h_cnt_q == H_MAX) || (v_cnt_q == V_MAX);
    end

    always_comb begin
        h_cnt_d    = hs_rise ? '0 : ((h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 1'b1);
        h_last_d   = hs_rise ? h_len : h_last_q;
        v_cnt_d    = vs_rise ? '0 : v_len;
        bad_line_d = vs_rise ? 1'b0 : frame_bad_line;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d    = state_q;
        h_ref_d    = h_ref_q;
        v_ref_d    = v_ref_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;

        if (watchdog) begin
            // Missing hsync or vsync wins over any frame decision on this clock.
            state_d = ST_SEARCH;
        end else if (vs_rise) begin
            case (state_q)
                ST_SEARCH: begin
                    h_ref_d    = h_last_d;
                    v_ref_d    = v_len;
                    good_cnt_d = '0;
                    state_d    = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (frame_good) begin
                        good_cnt_d = good_cnt_q + 1'b1;
                        if (good_cnt_q + 1'b1 == LOCK_TGT) begin
                            bad_cnt_d = '0;
                            state_d   = ST_LOCKED;
                        end
                    end else begin
                        h_ref_d    = h_last_d;
                        v_ref_d    = v_len;
                        good_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (frame_good) begin
                        bad_cnt_d = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 1'b1;
                        if (bad_cnt_q + 1'b1 == LOSS_TGT) begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // Outputs follow the next state so lock, totals and DE gating all change together.
    always_comb begin
        locked_d  = (state_d == ST_LOCKED);
        de_hist_d = {de_hist_q[1:0], display_enable};
        de_taps   = {de_hist_q, display_enable};
        de_out_d  = de_taps[de_delay] & locked_d;
        h_total_d = locked_d ? h_ref_d : '0;
        v_total_d = locked_d ? v_ref_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_dly_q       <= 1'b0;
            vs_dly_q       <= 1'b0;
            h_cnt_q        <= '0;
            h_last_q       <= '0;
            v_cnt_q        <= '0;
            bad_line_q     <= 1'b0;
            state_q        <= ST_SEARCH;
            h_ref_q        <= '0;
            v_ref_q        <= '0;
            good_cnt_q     <= '0;
            bad_cnt_q      <= '0;
            de_hist_q      <= '0;
            de_out_q       <= 1'b0;
            locked_q       <= 1'b0;
            frame_strobe_q <= 1'b0;
            h_total_q      <= '0;
            v_total_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            hs_dly_q       <= hsync;
            vs_dly_q       <= vsync;
            h_cnt_q        <= h_cnt_d;
            h_last_q       <= h_last_d;
            v_cnt_q        <= v_cnt_d;
            bad_line_q     <= bad_line_d;
            state_q        <= state_d;
            h_ref_q        <= h_ref_d;
            v_ref_q        <= v_ref_d;
            good_cnt_q     <= good_cnt_d;
            bad_cnt_q      <= bad_cnt_d;
            de_hist_q      <= de_hist_d;
            de_out_q       <= de_out_d;
            locked_q       <= locked_d;
            frame_strobe_q <= vs_rise;
            h_total_q      <= h_total_d;
            v_total_q      <= v_total_d;
        end
    end

    assign de_out       = de_out_q;
    assign locked       = locked_q;
    assign frame_strobe = frame_strobe_q;
    assign h_total      = h_total_q;
    assign v_total      = v_total_q;

endmodule

// File: tb/tb_hdmi_sync_lock_ctrl.sv
// Directed bench for hdmi_sync_lock_ctrl using scaled timing (48-clock lines,
// 20/21-line frames, 8-bit line counter) so every scenario runs in a few thousand clocks.
module tb_hdmi_sync_lock_ctrl;

    localparam int HCNT_W   = 8;
    localparam int VCNT_W   = 6;
    localparam int LINE     = 48;
    localparam int DE_LO    = 8;
    localparam int DE_HI    = 40;
    localparam int DE_LINES = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              hsync;
    logic              vsync;
    logic              display_enable;
    logic [1:0]        de_delay;
    logic              de_out;
    logic              locked;
    logic              frame_strobe;
    logic [HCNT_W-1:0] h_total;
    logic [VCNT_W-1:0] v_total;

    int checks = 0;
    int errors = 0;

    int strobe_cnt;
    int de_ones;
    int line_de_first;
    int line_de_ones;
    int probe_first;
    int probe_ones;
    logic              vs_locked;
    logic              vs_strobe;
    logic [HCNT_W-1:0] vs_htot;
    logic [VCNT_W-1:0] vs_vtot;

    hdmi_sync_lock_ctrl #(
        .HCNT_W(HCNT_W),
        .VCNT_W(VCNT_W),
        .HTOL(2),
        .LOCK_FRAMES(4),
        .LOSS_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .hsync(hsync),
        .vsync(vsync),
        .display_enable(display_enable),
        .de_delay(de_delay),
        .de_out(de_out),
        .locked(locked),
        .frame_strobe(frame_strobe),
        .h_total(h_total),
        .v_total(v_total)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_step(input logic hs, input logic vs, input logic de, input int x);
        hsync          = hs;
        vsync          = vs;
        display_enable = de;
        tick();
        if (frame_strobe) strobe_cnt++;
        if (de_out) begin
            de_ones++;
            line_de_ones++;
            if (line_de_first < 0) line_de_first = x;
        end
    endtask

    // Line ln: hsync high for x<4, vsync high for the whole of line 0, DE on x in [8,40).
    task automatic drive_line(input int len, input int ln);
        line_de_first = -1;
        line_de_ones  = 0;
        for (int x = 0; x < len; x++) begin
            drive_step(x < 4, ln == 0, (ln < DE_LINES) && (x >= DE_LO) && (x < DE_HI), x);
            if (ln == 0 && x == 0) begin
                vs_locked = locked;
                vs_strobe = frame_strobe;
                vs_htot   = h_total;
                vs_vtot   = v_total;
            end
        end
    endtask

    task automatic run_frame(input int nlines, input int start, input int len_e, input int len_o,
                             input int bad_ln, input int bad_len);
        int len;
        strobe_cnt = 0;
        de_ones    = 0;
        for (int ln = start; ln < nlines; ln++) begin
            len = (ln == bad_ln) ? bad_len : ((ln % 2 == 1) ? len_o : len_e);
            drive_line(len, ln);
            if (ln == 5) begin
                probe_first = line_de_first;
                probe_ones  = line_de_ones;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({locked, de_out, frame_strobe, h_total, v_total} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%b/%0d/%0d want all 0",
                     locked, de_out, frame_strobe, h_total, v_total);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if ({locked, de_out, frame_strobe, h_total, v_total} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b/%b/%b/%0d/%0d want all 0",
                     locked, de_out, frame_strobe, h_total, v_total);
        end
    endtask

    // Source starts at line 1, so the first vs_rise closes a complete 20-line frame.
    task automatic test_acquire_lock();
        run_frame(20, 1, LINE, LINE, -1, 0);
        checks++;
        if (strobe_cnt !== 0) begin
            errors++;
            $display("FAIL partial_frame_strobe: got %0d want 0", strobe_cnt);
        end
        for (int f = 1; f <= 5; f++) begin
            run_frame(20, 0, LINE, LINE, -1, 0);
            checks++;
            if (vs_locked !== (f == 5)) begin
                errors++;
                $display("FAIL acq_locked_vs%0d: got %b want %b", f, vs_locked, f == 5);
            end
            checks++;
            if (vs_strobe !== 1'b1 || strobe_cnt !== 1) begin
                errors++;
                $display("FAIL acq_strobe_vs%0d: got %b count %0d want 1 count 1", f, vs_strobe, strobe_cnt);
            end
            checks++;
            if (de_ones !== ((f == 5) ? 512 : 0)) begin
                errors++;
                $display("FAIL acq_de_ones_f%0d: got %0d want %0d", f, de_ones, (f == 5) ? 512 : 0);
            end
            checks++;
            if (vs_htot !== ((f == 5) ? 8'd48 : 8'd0) || vs_vtot !== ((f == 5) ? 6'd20 : 6'd0)) begin
                errors++;
                $display("FAIL acq_totals_vs%0d: got %0d/%0d", f, vs_htot, vs_vtot);
            end
        end
    endtask

    // 46/50 lines are within tolerance of 48; a single 51 line makes a frame bad.
    task automatic test_jitter();
        int bad_sel [6] = '{-1, -1, 7, -1, 7, -1};
        for (int i = 0; i < 6; i++) begin
            if (i < 2) run_frame(20, 0, 46, 50, -1, 0);
            else       run_frame(20, 0, LINE, LINE, bad_sel[i], 51);
            checks++;
            if (vs_locked !== 1'b1 || locked !== 1'b1) begin
                errors++;
                $display("FAIL jitter_locked_%0d: got %b/%b want 1/1", i, vs_locked, locked);
            end
        end
        checks++;
        if (h_total !== 8'd48 || v_total !== 6'd20) begin
            errors++;
            $display("FAIL jitter_totals: got %0d/%0d want 48/20", h_total, v_total);
        end
    endtask

    // Two 21-line frames drop lock; capture plus four good frames relock at 21.
    task automatic test_frame_loss();
        for (int r = 1; r <= 8; r++) begin
            run_frame(21, 0, LINE, LINE, -1, 0);
            checks++;
            if (vs_locked !== (r <= 2 || r == 8)) begin
                errors++;
                $display("FAIL loss_locked_r%0d: got %b want %b", r, vs_locked, (r <= 2 || r == 8));
            end
            if (r == 3 || r == 8) begin
                checks++;
                if (vs_htot !== ((r == 8) ? 8'd48 : 8'd0) || vs_vtot !== ((r == 8) ? 6'd21 : 6'd0)) begin
                    errors++;
                    $display("FAIL loss_totals_r%0d: got %0d/%0d", r, vs_htot, vs_vtot);
                end
            end
        end
    endtask

    // Last hsync rise is 48 samples back; h_cnt hits 255 after 256 samples, lock drops on 257.
    task automatic test_watchdog();
        for (int i = 1; i <= 208; i++) drive_step(1'b0, 1'b0, 1'b1, i);
        checks++;
        if (locked !== 1'b1 || de_out !== 1'b1) begin
            errors++;
            $display("FAIL wd_before: got locked %b de %b want 1/1", locked, de_out);
        end
        drive_step(1'b0, 1'b0, 1'b1, 209);
        checks++;
        if ({locked, de_out, h_total, v_total} !== '0) begin
            errors++;
            $display("FAIL wd_drop: got %b/%b/%0d/%0d want all 0", locked, de_out, h_total, v_total);
        end
        for (int k = 1; k <= 6; k++) begin
            run_frame(21, 0, LINE, LINE, -1, 0);
            checks++;
            if (vs_locked !== (k == 6)) begin
                errors++;
                $display("FAIL wd_relock_vs%0d: got %b want %b", k, vs_locked, k == 6);
            end
        end
        checks++;
        if (h_total !== 8'd48 || v_total !== 6'd21) begin
            errors++;
            $display("FAIL wd_totals: got %0d/%0d want 48/21", h_total, v_total);
        end
    endtask

    task automatic test_de_delay();
        for (int d = 0; d < 4; d++) begin
            de_delay = 2'(d);
            run_frame(21, 0, LINE, LINE, -1, 0);
            checks++;
            if (probe_first !== DE_LO + d || probe_ones !== 32) begin
                errors++;
                $display("FAIL de_delay_%0d: got first %0d ones %0d want %0d/32",
                         d, probe_first, probe_ones, DE_LO + d);
            end
        end
    endtask

    task automatic test_reset_mid();
        de_delay = 2'd2;
        for (int ln = 0; ln < 7; ln++) drive_line(LINE, ln);
        for (int x = 0; x < 20; x++) drive_step(x < 4, 1'b0, x >= DE_LO, x);
        checks++;
        if (locked !== 1'b1 || de_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_before_reset: got %b/%b want 1/1", locked, de_out);
        end
        reset_n = 1'b0;
        drive_step(1'b0, 1'b0, 1'b1, 20);
        reset_n = 1'b1;
        checks++;
        if ({locked, de_out, frame_strobe, h_total, v_total} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b/%b/%b/%0d/%0d want all 0",
                     locked, de_out, frame_strobe, h_total, v_total);
        end
        run_frame(21, 1, LINE, LINE, -1, 0);
        checks++;
        if (de_ones !== 0 || strobe_cnt !== 0) begin
            errors++;
            $display("FAIL unlocked_de: got ones %0d strobes %0d want 0/0", de_ones, strobe_cnt);
        end
        for (int k = 1; k <= 5; k++) begin
            run_frame(21, 0, LINE, LINE, -1, 0);
            checks++;
            if (vs_locked !== (k == 5)) begin
                errors++;
                $display("FAIL mid_relock_vs%0d: got %b want %b", k, vs_locked, k == 5);
            end
        end
        checks++;
        if (v_total !== 6'd21 || probe_first !== DE_LO + 2) begin
            errors++;
            $display("FAIL mid_relock_state: got v %0d first %0d want 21/%0d", v_total, probe_first, DE_LO + 2);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        hsync          = 1'b0;
        vsync          = 1'b0;
        display_enable = 1'b0;
        de_delay       = 2'd0;
        test_reset();
        test_acquire_lock();
        test_jitter();
        test_frame_loss();
        test_watchdog();
        test_de_delay();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
